// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared cpu encodings, bus widths and the ID/EX pipeline-control decode.
package id_ex_reg_pkg;
    localparam int DATA_BUS_W  = 32;
    localparam int ALUOP_BUS_W = 8;
    localparam int ALUSEL_BUS_W = 3;
    localparam int RADDR_BUS_W = 5;
    localparam int EXC_BUS_W   = 32;

    localparam logic [ALUOP_BUS_W-1:0]  NOP_OP        = 8'h00;
    localparam logic [ALUSEL_BUS_W-1:0] RES_NOP       = 3'b000;
    localparam logic                    WRITE_ENABLE  = 1'b1;
    localparam logic                    WRITE_DISABLE = 1'b0;
    localparam logic [DATA_BUS_W-1:0]   ZERO_WORD     = 32'h0000_0000;

    localparam int STALL_ID_BIT = 0;
    localparam int STALL_EX_BIT = 1;

    typedef enum logic [1:0] {ACT_ADVANCE, ACT_HOLD, ACT_BUBBLE, ACT_FLUSH} pipe_act_e;

    // Flush beats any stall; an EX stall holds regardless of the ID stall.
    function automatic pipe_act_e pipe_action(input logic flush, input logic [1:0] stall);
        return flush ? ACT_FLUSH :
               stall[STALL_EX_BIT] ? ACT_HOLD :
               stall[STALL_ID_BIT] ? ACT_BUBBLE : ACT_ADVANCE;
    endfunction
endpackage

// File: rtl/id_ex_perfcnt.sv
// id_ex_perfcnt: wrapping counters of issued instructions and inserted bubbles at ID/EX.
module id_ex_perfcnt
    import id_ex_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pipe_act_e   act_i,
    output logic [31:0] issue_cnt_o,
    output logic [31:0] bubble_cnt_o
);
    logic [31:0] issue_cnt_d, issue_cnt_q, bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        issue_cnt_d  = issue_cnt_q + 32'(act_i == ACT_ADVANCE);
        bubble_cnt_d = bubble_cnt_q + 32'(act_i == ACT_BUBBLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign issue_cnt_o  = issue_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID->EX pipeline register with flush/bubble/hold control.
// Define ID_EX_PERFCNT_EN to add issue/bubble performance counters.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W   = id_ex_reg_pkg::DATA_BUS_W,
    parameter int ALUOP_W  = id_ex_reg_pkg::ALUOP_BUS_W,
    parameter int ALUSEL_W = id_ex_reg_pkg::ALUSEL_BUS_W,
    parameter int RADDR_W  = id_ex_reg_pkg::RADDR_BUS_W,
    parameter int EXC_W    = id_ex_reg_pkg::EXC_BUS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_id_i,
    input  logic                stall_ex_i,
    input  logic                flush_i,
    input  logic [ALUOP_W-1:0]  id_aluop_i,
    input  logic [ALUSEL_W-1:0] id_alusel_i,
    input  logic [DATA_W-1:0]   id_reg1_i,
    input  logic [DATA_W-1:0]   id_reg2_i,
    input  logic [RADDR_W-1:0]  id_wd_i,
    input  logic                id_wreg_i,
    input  logic [31:0]         id_inst_i,
    input  logic [DATA_W-1:0]   id_link_addr_i,
    input  logic                id_in_delayslot_i,
    input  logic                next_in_delayslot_i,
    input  logic [EXC_W-1:0]    id_excepttype_i,
    input  logic [DATA_W-1:0]   id_pc_i,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic [ALUSEL_W-1:0] ex_alusel_o,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [RADDR_W-1:0]  ex_wd_o,
    output logic                ex_wreg_o,
    output logic [31:0]         ex_inst_o,
    output logic [DATA_W-1:0]   ex_link_addr_o,
    output logic                ex_in_delayslot_o,
    output logic [EXC_W-1:0]    ex_excepttype_o,
    output logic [DATA_W-1:0]   ex_pc_o,
    output logic                ex_valid_o,
    output logic                in_delayslot_o
`ifdef ID_EX_PERFCNT_EN
    ,
    output logic [31:0]         issue_cnt_o,
    output logic [31:0]         bubble_cnt_o
`endif
);
    localparam int W = ALUOP_W + ALUSEL_W + 4 * DATA_W + RADDR_W + EXC_W + 32 + 2;

    logic [W-1:0] id_bus, nop_bus, ex_d, ex_q;
    logic         valid_d, valid_q, ds_d, ds_q;
    logic [1:0]   stall;
    pipe_act_e    act;

    assign stall[STALL_ID_BIT] = stall_id_i;
    assign stall[STALL_EX_BIT] = stall_ex_i;
    assign act = pipe_action(flush_i, stall);

    assign id_bus = {id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
                     id_inst_i, id_link_addr_i, id_in_delayslot_i, id_excepttype_i, id_pc_i};
    // A NOP never writes back, so bubbles cannot trigger forwarding in EX.
    assign nop_bus = {ALUOP_W'(NOP_OP), ALUSEL_W'(RES_NOP), DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD),
                      RADDR_W'(0), WRITE_DISABLE, ZERO_WORD, DATA_W'(ZERO_WORD), 1'b0,
                      EXC_W'(ZERO_WORD), DATA_W'(ZERO_WORD)};

    always_comb begin
        ex_d    = act == ACT_ADVANCE ? id_bus : act == ACT_HOLD ? ex_q : nop_bus;
        valid_d = act == ACT_ADVANCE ? 1'b1 : act == ACT_HOLD ? valid_q : 1'b0;
        ds_d    = act == ACT_ADVANCE ? next_in_delayslot_i : act == ACT_FLUSH ? 1'b0 : ds_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
            ds_q    <= ds_d;
        end
    end

    assign {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
            ex_inst_o, ex_link_addr_o, ex_in_delayslot_o, ex_excepttype_o, ex_pc_o} = ex_q;
    assign ex_valid_o     = valid_q;
    assign in_delayslot_o = ds_q;

    // Stalls propagate backwards, so EX can never stall while ID runs.
    a_stall_order: assert property (@(posedge clk) disable iff (rst) !(stall_ex_i && !stall_id_i));

`ifdef ID_EX_PERFCNT_EN
    id_ex_perfcnt u_perfcnt (
        .clk          (clk),
        .rst          (rst),
        .act_i        (act),
        .issue_cnt_o  (issue_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: table-driven scoreboard bench for the ID/EX pipeline register.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        stall_id_i = 1'b0, stall_ex_i = 1'b0, flush_i = 1'b0;
    logic [7:0]  id_aluop_i = '0;
    logic [2:0]  id_alusel_i = '0;
    logic [31:0] id_reg1_i = '0, id_reg2_i = '0, id_inst_i = '0, id_link_addr_i = '0;
    logic [31:0] id_excepttype_i = '0, id_pc_i = '0;
    logic [4:0]  id_wd_i = '0;
    logic        id_wreg_i = 1'b0, id_in_delayslot_i = 1'b0, next_in_delayslot_i = 1'b0;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o, ex_reg2_o, ex_inst_o, ex_link_addr_o, ex_excepttype_o, ex_pc_o;
    logic [4:0]  ex_wd_o;
    logic        ex_wreg_o, ex_in_delayslot_o, ex_valid_o, in_delayslot_o;
`ifdef ID_EX_PERFCNT_EN
    logic [31:0] issue_cnt_o, bubble_cnt_o;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall_id_i(stall_id_i), .stall_ex_i(stall_ex_i), .flush_i(flush_i),
        .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i), .id_reg1_i(id_reg1_i),
        .id_reg2_i(id_reg2_i), .id_wd_i(id_wd_i), .id_wreg_i(id_wreg_i), .id_inst_i(id_inst_i),
        .id_link_addr_i(id_link_addr_i), .id_in_delayslot_i(id_in_delayslot_i),
        .next_in_delayslot_i(next_in_delayslot_i), .id_excepttype_i(id_excepttype_i),
        .id_pc_i(id_pc_i), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_inst_o(ex_inst_o), .ex_link_addr_o(ex_link_addr_o),
        .ex_in_delayslot_o(ex_in_delayslot_o), .ex_excepttype_o(ex_excepttype_o),
        .ex_pc_o(ex_pc_o), .ex_valid_o(ex_valid_o), .in_delayslot_o(in_delayslot_o)
`ifdef ID_EX_PERFCNT_EN
        , .issue_cnt_o(issue_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    typedef struct {
        logic fl, sid, sex;
        logic [7:0] op; logic [2:0] sel; logic [31:0] r1, r2; logic [4:0] wd;
        logic wr, ids, nds; logic [31:0] pc;
        logic [7:0] eop; logic [2:0] esel; logic [31:0] er1, er2; logic [4:0] ewd;
        logic ewr, evalid, eids, eind; logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] op, sel, r1, r2, wd, wr, inst, link, ids, exc, pc, valid, ind;
    } exp_t;

    vec_t v[12];
    exp_t sb[$];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        exp_t e;
        flush_i = x.fl; stall_id_i = x.sid; stall_ex_i = x.sex;
        id_aluop_i = x.op; id_alusel_i = x.sel; id_reg1_i = x.r1; id_reg2_i = x.r2;
        id_wd_i = x.wd; id_wreg_i = x.wr; id_in_delayslot_i = x.ids; next_in_delayslot_i = x.nds;
        id_pc_i = x.pc; id_inst_i = x.r1 ^ K; id_link_addr_i = x.pc + 32'd8;
        id_excepttype_i = {x.pc[15:0], x.r2[15:0]};
        e.op = 32'(x.eop); e.sel = 32'(x.esel); e.r1 = x.er1; e.r2 = x.er2; e.wd = 32'(x.ewd);
        e.wr = 32'(x.ewr); e.ids = 32'(x.eids); e.pc = x.epc; e.valid = 32'(x.evalid);
        e.ind = 32'(x.eind);
        e.inst = x.evalid ? x.er1 ^ K : 32'h0;
        e.link = x.evalid ? x.epc + 32'd8 : 32'h0;
        e.exc  = x.evalid ? {x.epc[15:0], x.er2[15:0]} : 32'h0;
        sb.push_back(e);
    endtask

    task automatic compare(input int i);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_underflow: row %0d got no expectation, expected one", i);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("aluop[%0d]", i), 32'(ex_aluop_o), e.op);
        chk($sformatf("alusel[%0d]", i), 32'(ex_alusel_o), e.sel);
        chk($sformatf("reg1[%0d]", i), ex_reg1_o, e.r1);
        chk($sformatf("reg2[%0d]", i), ex_reg2_o, e.r2);
        chk($sformatf("wd[%0d]", i), 32'(ex_wd_o), e.wd);
        chk($sformatf("wreg[%0d]", i), 32'(ex_wreg_o), e.wr);
        chk($sformatf("inst[%0d]", i), ex_inst_o, e.inst);
        chk($sformatf("link[%0d]", i), ex_link_addr_o, e.link);
        chk($sformatf("ex_ds[%0d]", i), 32'(ex_in_delayslot_o), e.ids);
        chk($sformatf("exc[%0d]", i), ex_excepttype_o, e.exc);
        chk($sformatf("pc[%0d]", i), ex_pc_o, e.pc);
        chk($sformatf("valid[%0d]", i), 32'(ex_valid_o), e.valid);
        chk($sformatf("in_ds[%0d]", i), 32'(in_delayslot_o), e.ind);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        fl    sid   sex   op     sel   r1            r2            wd     wr    ids   nds   pc        | eop  esel  er1           er2           ewd    ewr   evld  eids  eind  epc
        v[0]  = '{1'b0, 1'b0, 1'b0, 8'h25, 3'd1, 32'h0000F0F0, 32'h00000F0F, 5'd5,  1'b1, 1'b0, 1'b0, 32'h100, 8'h25, 3'd1, 32'h0000F0F0, 32'h00000F0F, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 32'h100};
        v[1]  = '{1'b0, 1'b0, 1'b0, 8'h20, 3'd4, 32'h11111111, 32'h22222222, 5'd7,  1'b1, 1'b0, 1'b1, 32'h104, 8'h20, 3'd4, 32'h11111111, 32'h22222222, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 32'h104};
        v[2]  = '{1'b0, 1'b1, 1'b0, 8'h20, 3'd4, 32'hAAAA0000, 32'h00005555, 5'd4,  1'b1, 1'b1, 1'b0, 32'h108, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        v[3]  = '{1'b0, 1'b0, 1'b0, 8'h25, 3'd1, 32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b1, 1'b0, 32'h108, 8'h25, 3'd1, 32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'h108};
        v[4]  = '{1'b0, 1'b1, 1'b1, 8'h20, 3'd4, 32'hDEADBEEF, 32'h00000001, 5'd3,  1'b1, 1'b0, 1'b1, 32'h10C, 8'h25, 3'd1, 32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'h108};
        v[5]  = '{1'b0, 1'b1, 1'b1, 8'h20, 3'd4, 32'hCAFEBABE, 32'h00000002, 5'd3,  1'b1, 1'b0, 1'b1, 32'h10C, 8'h25, 3'd1, 32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'h108};
        v[6]  = '{1'b0, 1'b1, 1'b1, 8'h20, 3'd4, 32'h0BADF00D, 32'h00000003, 5'd3,  1'b1, 1'b0, 1'b1, 32'h10C, 8'h25, 3'd1, 32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'h108};
        v[7]  = '{1'b0, 1'b0, 1'b0, 8'h20, 3'd4, 32'h33333333, 32'h44444444, 5'd12, 1'b1, 1'b0, 1'b1, 32'h10C, 8'h20, 3'd4, 32'h33333333, 32'h44444444, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10C};
        v[8]  = '{1'b1, 1'b1, 1'b1, 8'h25, 3'd1, 32'h77777777, 32'h88888888, 5'd1,  1'b1, 1'b1, 1'b1, 32'h110, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        v[9]  = '{1'b0, 1'b0, 1'b0, 8'h25, 3'd1, 32'h0000000F, 32'h0000000E, 5'd31, 1'b0, 1'b0, 1'b1, 32'h110, 8'h25, 3'd1, 32'h0000000F, 32'h0000000E, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 32'h110};
        v[10] = '{1'b1, 1'b0, 1'b0, 8'h20, 3'd4, 32'h00000009, 32'h00000009, 5'd2,  1'b1, 1'b1, 1'b1, 32'h114, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        v[11] = '{1'b0, 1'b1, 1'b1, 8'h25, 3'd1, 32'h00000005, 32'h00000006, 5'd8,  1'b1, 1'b0, 1'b1, 32'h118, 8'h00, 3'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(ex_valid_o), 32'h0);
        chk("rst_aluop", 32'(ex_aluop_o), 32'h0);
        chk("rst_wreg", 32'(ex_wreg_o), 32'h0);
        chk("rst_reg1", ex_reg1_o, 32'h0);
        chk("rst_in_ds", 32'(in_delayslot_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(v[i]);
            @(posedge clk);
            #1;
            compare(i);
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);
`ifdef ID_EX_PERFCNT_EN
        chk("issue_cnt", issue_cnt_o, 32'd5);
        chk("bubble_cnt", bubble_cnt_o, 32'd1);
`endif

        // Asynchronous reset in the middle of a hold, before the next edge.
        @(negedge clk);
        drive(v[7]);
        @(posedge clk);
        #1;
        compare(7);
        @(negedge clk);
        stall_id_i = 1'b1;
        stall_ex_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ex_valid_o), 32'h0);
        chk("arst_aluop", 32'(ex_aluop_o), 32'h0);
        chk("arst_reg1", ex_reg1_o, 32'h0);
        chk("arst_wreg", 32'(ex_wreg_o), 32'h0);
        chk("arst_pc", ex_pc_o, 32'h0);
        chk("arst_in_ds", 32'(in_delayslot_o), 32'h0);
`ifdef ID_EX_PERFCNT_EN
        chk("arst_issue_cnt", issue_cnt_o, 32'd0);
        chk("arst_bubble_cnt", bubble_cnt_o, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        stall_id_i = 1'b0;
        stall_ex_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode (ID) stage and the execute (EX) stage of the 5-stage MIPS core.
- Captures decoded ALU op, ALU select, operand values, destination register and delay-slot/exception context every cycle.
- Applies stall, bubble-insertion and flush rules so that EX, including the logic-operation unit, always sees either a valid instruction or a clean NOP.

Parameters:
- DATA_W, 32, operand/result width
- ALUOP_W, 8, ALU operation code width
- ALUSEL_W, 3, ALU result-select width
- RADDR_W, 5, register-file address width
- EXC_W, 32, exception-type vector width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_id_i  in  1  ID stage stalled this cycle
- stall_ex_i  in  1  EX stage stalled this cycle
- flush_i  in  1  exception flush; kills the instruction in this register
- id_aluop_i  in  ALUOP_W  decoded ALU op
- id_alusel_i  in  ALUSEL_W  decoded result select
- id_reg1_i  in  DATA_W  operand 1
- id_reg2_i  in  DATA_W  operand 2
- id_wd_i  in  RADDR_W  destination register
- id_wreg_i  in  1  destination write enable
- id_inst_i  in  32  raw instruction word (for load/store offset)
- id_link_addr_i  in  DATA_W  return address for JAL/BAL
- id_in_delayslot_i  in  1  current ID instruction is in a delay slot
- next_in_delayslot_i  in  1  next instruction entering ID is a delay slot
- id_excepttype_i  in  EXC_W  exception flags from ID
- id_pc_i  in  DATA_W  PC of ID instruction
- ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_o, ex_link_addr_o, ex_in_delayslot_o, ex_excepttype_o, ex_pc_o  out  widths as inputs  registered copies to EX
- ex_valid_o  out  1  register holds a real instruction, not a bubble
- in_delayslot_o  out  1  to ID: instruction now in ID is a delay slot

Behaviour:
- Async reset: all outputs 0. ex_aluop_o is the NOP op (0), ex_alusel_o is the NOP result select (0), ex_wreg_o is write-disable (0), ex_valid_o is 0, in_delayslot_o is 0.
- Per-edge priority, highest first:
  1. flush_i=1: load NOP (all EX outputs 0, ex_valid_o=0) and clear in_delayslot_o.
  2. Bubble (stall_id_i=1, stall_ex_i=0): load NOP into EX outputs, ex_valid_o=0; hold in_delayslot_o.
  3. Hold (stall_ex_i=1): all outputs keep their values.
  4. Advance (stall_id_i=0, stall_ex_i=0): load every id_* input into the matching ex_* output, ex_valid_o=1, in_delayslot_o <= next_in_delayslot_i.
- stall_id_i=0 with stall_ex_i=1 is illegal, because stalls propagate backwards. Treat it as hold; an assertion flags it in simulation.
- Latency: exactly 1 cycle from ID inputs to EX outputs on an advance.
- A bubble forces ex_wreg_o=0, so no register write or forwarding hit comes from a bubble.
- Flush during hold still clears the register. Flush wins over every stall combination.
- Reset asserted mid-stall clears immediately, without waiting for a clock edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro ID_EX_PERFCNT_EN.
- When defined, the block adds:
  - issue_cnt_o (32-bit) counts advance edges.
  - bubble_cnt_o (32-bit) counts bubble edges.
  - Both counters wrap at 2^32, reset to 0, and freeze during hold.
  - Flush counts as neither.
- When undefined, these ports and counters are absent and nothing else in the block changes.

Decomposition:
- Shared cpu package holds:
  - NOP_OP and RES_NOP encodings
  - write-enable/disable constants
  - zero-word constant
  - bus widths
  - stall-vector bit indices
- Natural sub-module: id_ex_perfcnt, instantiated only under ID_EX_PERFCNT_EN.
- The datapath register stays flat in id_ex_reg.

Test Plan:
- Reset: assert rst between edges with nonzero state → all outputs 0 immediately; ex_valid_o=0.
- Advance: id_aluop_i=OR op, id_reg1_i=0x0000F0F0, id_reg2_i=0x00000F0F, id_wd_i=5, id_wreg_i=1 → next edge: same values on ex_* outputs, ex_valid_o=1.
- Bubble: stall_id_i=1, stall_ex_i=0 with a valid ADD in ID → next edge: ex_aluop_o=0, ex_wreg_o=0, ex_valid_o=0; in_delayslot_o unchanged. With the feature on, bubble_cnt_o increments by 1.
- Hold: load 0x12345678 into ex_reg1_o, then stall_ex_i=stall_id_i=1 for 3 cycles while id_reg1_i changes → ex_reg1_o stays 0x12345678.
- Flush: flush_i=1 together with stall_ex_i=1 and in_delayslot_o=1 → next edge: all EX outputs 0, in_delayslot_o=0.
- Delay slot: branch advances with next_in_delayslot_i=1 → in_delayslot_o=1. Next advance, with id_in_delayslot_i=1 → ex_in_delayslot_o=1.
